// File: rtl/mac_seq_if.sv
// Bus bundle for mac_seq: vector-memory read port, MAC operand/result port and
// the result stream.
//   master (mac_seq side): drives mem_rd_en, mem_addr, mac_p, mac_w,
//                          res_data, res_valid, res_idx
//   slave  (environment) : drives mem_pixel, mem_weight, mac_sum, res_ready
// Parameters: DW = pixel/weight word width, SW = MAC sum width.
interface mac_seq_if #(
   parameter int unsigned DW = 128,
   parameter int unsigned SW = 20
);
   logic          mem_rd_en;
   logic [5:0]    mem_addr;
   logic [DW-1:0] mem_pixel;
   logic [DW-1:0] mem_weight;
   logic [DW-1:0] mac_p;
   logic [DW-1:0] mac_w;
   logic [SW-1:0] mac_sum;
   logic [SW-1:0] res_data;
   logic          res_valid;
   logic          res_ready;
   logic [5:0]    res_idx;

   modport master (
      output mem_rd_en, mem_addr, mac_p, mac_w, res_data, res_valid, res_idx,
      input  mem_pixel, mem_weight, mac_sum, res_ready
   );

   modport slave (
      input  mem_rd_en, mem_addr, mac_p, mac_w, res_data, res_valid, res_idx,
      output mem_pixel, mem_weight, mac_sum, res_ready
   );
endinterface

// File: rtl/mac_seq.sv
// mac_seq: sequences N_VEC pixel/weight vector reads through an external MAC
// and streams the signed sums out, in index order, through a small FIFO.
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   start           begin a run (sampled only in IDLE)
//   busy            high in every state except IDLE
//   done            one-cycle pulse when the run completes
//   bus (master)    memory read port, MAC operands/sum, result stream
//   max_idx/max_val argmax of the run's sums, only when MAC_SEQ_ARGMAX_EN is
//                   defined
// Optional feature macro: MAC_SEQ_ARGMAX_EN.
module mac_seq #(
   parameter int unsigned N_VEC      = 40,
   parameter int unsigned DW         = 128,
   parameter int unsigned SW         = 20,
   parameter int unsigned MAC_LAT    = 1,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic          busy,
   output logic          done,
`ifdef MAC_SEQ_ARGMAX_EN
   output logic [5:0]    max_idx,
   output logic [SW-1:0] max_val,
`endif
   mac_seq_if.master     bus
);
   localparam int unsigned PL = 2 + MAC_LAT;
   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned KW = $clog2(FIFO_DEPTH + PL + 1) + 1;
   localparam logic [5:0]  LAST_IDX = 6'(N_VEC - 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t        state;
   logic [5:0]    rd_idx;
   logic [PL-1:0] pv;
   logic [5:0]    pidx   [PL];
   logic [SW-1:0] q_data [FIFO_DEPTH];
   logic [5:0]    q_idx  [FIFO_DEPTH];
   logic [CW-1:0] cnt;

   logic          push_c;
   logic          pop_c;
   logic          rd_go_c;
   logic          drain_empty_c;
   logic [KW-1:0] inflight_c;
   logic [CW-1:0] cnt_nxt_c;
   logic [AW-1:0] wr_c;

   // Credit check: occupancy is taken after this cycle's pop so that a
   // continuously drained stream sustains one read per cycle, while the total
   // of FIFO entries plus in-flight reads can never exceed FIFO_DEPTH.
   always_comb begin
      inflight_c = '0;
      for (int i = 0; i < int'(PL); i++) inflight_c = inflight_c + KW'(pv[i]);
      push_c        = pv[PL-1];
      pop_c         = bus.res_valid & bus.res_ready;
      cnt_nxt_c     = cnt + CW'(push_c) - CW'(pop_c);
      wr_c          = AW'(cnt - CW'(pop_c));
      rd_go_c       = (state == RUN) &&
                      ((KW'(cnt) - KW'(pop_c) + inflight_c) < KW'(FIFO_DEPTH));
      drain_empty_c = (pv == '0) && (cnt == CW'(pop_c));
   end

   assign bus.mem_rd_en = rd_go_c;
   assign bus.mem_addr  = rd_idx;
   assign bus.res_data  = q_data[0];
   assign bus.res_idx   = q_idx[0];

   // Control FSM; rd_idx is the index of the read presented in this cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         rd_idx <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state  <= RUN;
                  busy   <= 1'b1;
                  rd_idx <= '0;
               end
            end
            RUN: begin
               if (rd_go_c) begin
                  if (rd_idx == LAST_IDX) state <= DRAIN;
                  else                    rd_idx <= rd_idx + 6'd1;
               end
            end
            DRAIN: begin
               if (drain_empty_c) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // In-flight valid/index pipe; stage 0 is the cycle the memory data arrives.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pv        <= '0;
         bus.mac_p <= DW'(0);
         bus.mac_w <= DW'(0);
         for (int i = 0; i < int'(PL); i++) pidx[i] <= '0;
      end else begin
         pv      <= {pv[PL-2:0], rd_go_c};
         pidx[0] <= rd_idx;
         for (int i = 1; i < int'(PL); i++) pidx[i] <= pidx[i-1];
         if (pv[0]) begin
            bus.mac_p <= bus.mem_pixel;
            bus.mac_w <= bus.mem_weight;
         end
      end
   end

   // Shifting result FIFO: entry 0 is the head, so the stream outputs are flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt           <= '0;
         bus.res_valid <= 1'b0;
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            q_data[i] <= SW'(0);
            q_idx[i]  <= '0;
         end
      end else begin
         if (pop_c) begin
            for (int i = 0; i < int'(FIFO_DEPTH) - 1; i++) begin
               q_data[i] <= q_data[i+1];
               q_idx[i]  <= q_idx[i+1];
            end
         end
         if (push_c) begin
            q_data[wr_c] <= bus.mac_sum;
            q_idx[wr_c]  <= pidx[PL-1];
         end
         cnt           <= cnt_nxt_c;
         bus.res_valid <= (cnt_nxt_c != '0);
      end
   end

`ifdef MAC_SEQ_ARGMAX_EN
   logic have_max;

   // Strict greater-than keeps the lowest index on ties (pushes arrive in order).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         have_max <= 1'b0;
         max_idx  <= '0;
         max_val  <= SW'(0);
      end else if ((state == IDLE) && start) begin
         have_max <= 1'b0;
         max_idx  <= '0;
         max_val  <= SW'(0);
      end else if (push_c && (!have_max || ($signed(bus.mac_sum) > $signed(max_val)))) begin
         have_max <= 1'b1;
         max_idx  <= pidx[PL-1];
         max_val  <= bus.mac_sum;
      end
   end
`endif
endmodule

// File: tb/tb_mac_seq.sv
// Testbench for mac_seq: memory and MAC models, scoreboard of expected
// results filled at each start, and an independent output monitor.
module tb_mac_seq;
   localparam int unsigned DW         = 128;
   localparam int unsigned SW         = 20;
   localparam int unsigned MAC_LAT    = 1;
   localparam int unsigned FIFO_DEPTH = 4;
`ifdef MAC_SEQ_ARGMAX_EN
   localparam int unsigned N_VEC      = 5;
`else
   localparam int unsigned N_VEC      = 40;
`endif

   typedef struct packed {
      logic [5:0]    idx;
      logic [SW-1:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic busy;
   logic done;
`ifdef MAC_SEQ_ARGMAX_EN
   logic [5:0]    max_idx;
   logic [SW-1:0] max_val;
`endif

   mac_seq_if #(.DW(DW), .SW(SW)) bus ();

   mac_seq #(
      .N_VEC(N_VEC), .DW(DW), .SW(SW), .MAC_LAT(MAC_LAT), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .busy(busy),
      .done(done),
`ifdef MAC_SEQ_ARGMAX_EN
      .max_idx(max_idx),
      .max_val(max_val),
`endif
      .bus(bus)
   );

   always #5 clk = ~clk;

   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   int   rdy_mode = 0;
   int   run_base = 0;
   int   rd_cnt = 0, acc_cnt = 0, done_cnt = 0;
   int   rd0 = 0, acc0 = 0, done0 = 0;
   int   first_rd = -1, first_val = -1, first_acc = -1, last_acc = -1;
   logic hold = 1'b0;
   exp_t held;
   exp_t got;
   exp_t sb [$];

   always @(posedge clk) cyc <= cyc + 1;

   // Hand-computed sums: index*3 by default, a fixed signed table for argmax.
   function automatic logic [SW-1:0] exp_sum(input int i);
`ifdef MAC_SEQ_ARGMAX_EN
      case (i)
         0:       return SW'(5);
         1:       return SW'(-3);
         2:       return SW'(9);
         3:       return SW'(9);
         default: return SW'(2);
      endcase
`else
      return SW'(i * 3);
`endif
   endfunction

   // Vector memory: data one cycle after the read strobe.
   always @(posedge clk) begin
      if (bus.mem_rd_en) begin
`ifdef MAC_SEQ_ARGMAX_EN
         bus.mem_pixel  <= DW'(1);
         bus.mem_weight <= DW'($signed(exp_sum(int'(bus.mem_addr))));
`else
         bus.mem_pixel  <= DW'(bus.mem_addr);
         bus.mem_weight <= DW'(3);
`endif
      end
   end

   // MAC: product of the registered operands, MAC_LAT cycles later.
   logic [SW-1:0] mac_pipe [MAC_LAT];
   always @(posedge clk) begin
      mac_pipe[0] <= SW'(bus.mac_p * bus.mac_w);
      for (int i = 1; i < int'(MAC_LAT); i++) mac_pipe[i] <= mac_pipe[i-1];
   end
   assign bus.mac_sum = mac_pipe[MAC_LAT-1];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Result acceptance ready pattern, updated just after each rising edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       bus.res_ready = 1'b1;
            1:       bus.res_ready = !(((cyc - run_base) >= 10) && ((cyc - run_base) <= 30));
            default: bus.res_ready = !bus.res_ready;
         endcase
      end
   end

   // Monitor: hold stability, in-order scoreboard compare, event counters.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            hold = 1'b0;
            continue;
         end
         if (bus.mem_rd_en) begin
            rd_cnt++;
            if (first_rd < 0) first_rd = cyc;
         end
         if (bus.res_valid && (first_val < 0)) first_val = cyc;
         if (done) done_cnt++;
         if (hold)
            chk("hold_stable", 128'({bus.res_valid, bus.res_idx, bus.res_data}),
                128'({1'b1, held.idx, held.data}));
         if (bus.res_valid && bus.res_ready) begin
            if (sb.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_result: got idx %0d data 0x%0h, scoreboard empty",
                        bus.res_idx, bus.res_data);
            end else begin
               got = sb.pop_front();
               chk("res_idx", 128'(bus.res_idx), 128'(got.idx));
               chk("res_data", 128'(bus.res_data), 128'(got.data));
            end
            acc_cnt++;
            last_acc = cyc;
            if (first_acc < 0) first_acc = cyc;
         end
         hold = bus.res_valid && !bus.res_ready;
         held = '{idx: bus.res_idx, data: bus.res_data};
      end
   end

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_busy"},      128'(busy),          128'(0));
      chk({tag, "_done"},      128'(done),          128'(0));
      chk({tag, "_mem_rd_en"}, 128'(bus.mem_rd_en), 128'(0));
      chk({tag, "_mem_addr"},  128'(bus.mem_addr),  128'(0));
      chk({tag, "_mac_p"},     128'(bus.mac_p),     128'(0));
      chk({tag, "_mac_w"},     128'(bus.mac_w),     128'(0));
      chk({tag, "_res_valid"}, 128'(bus.res_valid), 128'(0));
      chk({tag, "_res_data"},  128'(bus.res_data),  128'(0));
      chk({tag, "_res_idx"},   128'(bus.res_idx),   128'(0));
   endtask

   // Issue a start and push the whole run's expected results.
   task automatic start_run(input int mode, input bit keep_start);
      for (int i = 0; i < int'(N_VEC); i++) sb.push_back('{idx: 6'(i), data: exp_sum(i)});
      first_rd  = -1;
      first_val = -1;
      first_acc = -1;
      rd0   = rd_cnt;
      acc0  = acc_cnt;
      done0 = done_cnt;
      @(posedge clk);
      #1;
      rdy_mode = mode;
      run_base = cyc;
      start    = 1'b1;
      @(posedge clk);
      #1;
      if (!keep_start) start = 1'b0;
      @(negedge clk);
      #2;
      chk("busy_in_run", 128'(busy), 128'(1));
   endtask

   task automatic wait_done(input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         #2;
         if (done_cnt != done0) begin
            seen = 1'b1;
            break;
         end
      end
      start = 1'b0;
      chk({tag, "_done_seen"}, 128'(seen), 128'(1));
      repeat (3) @(negedge clk);
      #2;
      chk({tag, "_done_once"}, 128'(done_cnt - done0), 128'(1));
      chk({tag, "_idle"},      128'(busy),              128'(0));
      chk({tag, "_n_results"}, 128'(acc_cnt - acc0),    128'(N_VEC));
      chk({tag, "_sb_empty"},  128'(sb.size()),         128'(0));
   endtask

   initial begin
      rst           = 1'b1;
      start         = 1'b0;
      bus.res_ready = 1'b1;
      bus.mem_pixel  = '0;
      bus.mem_weight = '0;
      for (int i = 0; i < int'(MAC_LAT); i++) mac_pipe[i] = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_vals("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Free-flowing run: latency and one result per cycle.
      start_run(0, 1'b0);
      wait_done("basic");
      chk("first_latency", 128'(first_val - first_rd), 128'(4));
      chk("throughput",    128'(last_acc - first_acc), 128'(N_VEC - 1));
`ifdef MAC_SEQ_ARGMAX_EN
      chk("max_idx", 128'(max_idx), 128'(2));
      chk("max_val", 128'(max_val), 128'(SW'(9)));
      repeat (4) @(negedge clk);
      chk("max_idx_stable", 128'(max_idx), 128'(2));
      chk("max_val_stable", 128'(max_val), 128'(SW'(9)));
`else
      // Back-pressure window: reads stall at full credit.
      start_run(1, 1'b0);
      while ((cyc - run_base) < 28) @(negedge clk);
      #2;
      chk("stall_rd_en",       128'(bus.mem_rd_en),                        128'(0));
      chk("stall_res_valid",   128'(bus.res_valid),                        128'(1));
      chk("stall_outstanding", 128'((rd_cnt - rd0) - (acc_cnt - acc0)),    128'(FIFO_DEPTH));
      wait_done("stall");

      // Ready toggling every cycle.
      start_run(2, 1'b0);
      wait_done("toggle");

      // Reset in the middle of a run, then a clean rerun.
      start_run(0, 1'b0);
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         #2;
         if ((acc_cnt - acc0) >= 17) break;
      end
      chk("reached_17", 128'(acc_cnt - acc0), 128'(17));
      #1;
      rst = 1'b1;
      #1;
      chk_reset_vals("async_rst");
      sb.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (10) @(negedge clk);
      #2;
      chk("post_rst_idle",  128'(busy),          128'(0));
      chk("post_rst_valid", 128'(bus.res_valid), 128'(0));
      start_run(0, 1'b0);
      wait_done("rerun");

      // start held high through the whole run.
      start_run(0, 1'b1);
      wait_done("start_held");
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
